// File: rtl/alu_result_collector_if.sv
// rtl/alu_result_collector_if.sv - ALU result inputs and collector output stream bundle
interface alu_result_collector_if #(
  parameter int Width      = 16,
  parameter int Addr_Width = 2
);
  logic [2*Width-1:0]  Arith_OUT;
  logic [Width-1:0]    Logic_OUT;
  logic [Width-1:0]    CMP_OUT;
  logic [Width-1:0]    Shift_OUT;
  logic                Arith_Flag;
  logic                Logic_Flag;
  logic                CMP_Flag;
  logic                Shift_Flag;
  logic                Clr_Err;
  logic                Res_Ready;
  logic                Res_Valid;
  logic [2*Width-1:0]  Res_Data;
  logic [1:0]          Res_Unit;
  logic [Addr_Width:0] Count;
  logic                Busy;
  logic                Overflow;
  logic                Multi_Err;

  modport master (
    output Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    output Clr_Err, Res_Ready,
    input  Res_Valid, Res_Data, Res_Unit, Count, Busy, Overflow, Multi_Err
  );

  modport slave (
    input  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    input  Clr_Err, Res_Ready,
    output Res_Valid, Res_Data, Res_Unit, Count, Busy, Overflow, Multi_Err
  );
endinterface

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - tags ALU unit results and queues them in a show-ahead FIFO
module alu_result_collector #(
  parameter int Width      = 16,
  parameter int Addr_Width = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  alu_result_collector_if.slave bus
);
  localparam int Depth = 2 ** Addr_Width;
  localparam logic [Addr_Width:0] C_FULL = (Addr_Width + 1)'(Depth);
  localparam logic [Addr_Width:0] C_BUSY = (Addr_Width + 1)'(Depth - 1);

  logic [2*Width-1:0]    r_mem_data [Depth];
  logic [1:0]            r_mem_unit [Depth];
  logic [Addr_Width-1:0] r_wr_ptr;
  logic [Addr_Width-1:0] r_rd_ptr;
  logic [Addr_Width:0]   r_count;
  logic                  r_overflow;
  logic                  r_multi_err;

  logic                  w_push;
  logic                  w_multi;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_drop;
  logic [2*Width-1:0]    w_data;
  logic [1:0]            w_unit;

  assign w_push  = bus.Arith_Flag | bus.Logic_Flag | bus.CMP_Flag | bus.Shift_Flag;
  assign w_multi = (bus.Arith_Flag & (bus.Logic_Flag | bus.CMP_Flag | bus.Shift_Flag))
                 | (bus.Logic_Flag & (bus.CMP_Flag | bus.Shift_Flag))
                 | (bus.CMP_Flag & bus.Shift_Flag);

  // Fixed priority Arith > Logic > CMP > Shift; narrow units are zero-extended
  always_comb begin
    w_data = '0;
    w_unit = 2'b00;
    if (bus.Arith_Flag) begin
      w_data = bus.Arith_OUT;
      w_unit = 2'b00;
    end else if (bus.Logic_Flag) begin
      w_data = {{Width{1'b0}}, bus.Logic_OUT};
      w_unit = 2'b01;
    end else if (bus.CMP_Flag) begin
      w_data = {{Width{1'b0}}, bus.CMP_OUT};
      w_unit = 2'b10;
    end else if (bus.Shift_Flag) begin
      w_data = {{Width{1'b0}}, bus.Shift_OUT};
      w_unit = 2'b11;
    end
  end

  // Occupancy alone decides full/empty, so pointers may wrap freely
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = !w_empty && bus.Res_Ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= w_data;
      r_mem_unit[r_wr_ptr] <= w_unit;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop)
        r_count <= r_count - 1'b1;
      // A new error event on the same edge as Clr_Err keeps the bit set
      if (w_drop)
        r_overflow <= 1'b1;
      else if (bus.Clr_Err)
        r_overflow <= 1'b0;
      if (w_multi)
        r_multi_err <= 1'b1;
      else if (bus.Clr_Err)
        r_multi_err <= 1'b0;
    end
  end

  assign bus.Res_Valid = !w_empty;
  assign bus.Res_Data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.Res_Unit  = w_empty ? 2'b00 : r_mem_unit[r_rd_ptr];
  assign bus.Count     = r_count;
  assign bus.Busy      = (r_count >= C_BUSY);
  assign bus.Overflow  = r_overflow;
  assign bus.Multi_Err = r_multi_err;
endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Sink-side companion to the 16-bit ALU top. Watches the four registered unit result buses and their one-cycle valid flags, tags each result with its source unit, and pushes it into a small show-ahead FIFO. Results leave on a single valid/ready stream. The FIFO absorbs downstream backpressure that the ALU itself cannot handle, and Busy tells the operation issuer to stop issuing.

Parameters:
Width, 16, operand width of the ALU; result data path is 2*Width
Addr_Width, 2, FIFO pointer width; Depth = 2**Addr_Width (default 4 entries)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
Arith_OUT  input  2*Width  arithmetic unit result
Logic_OUT  input  Width  logic unit result
CMP_OUT  input  Width  compare unit result
Shift_OUT  input  Width  shift unit result
Arith_Flag  input  1  Arith_OUT valid this cycle
Logic_Flag  input  1  Logic_OUT valid this cycle
CMP_Flag  input  1  CMP_OUT valid this cycle
Shift_Flag  input  1  Shift_OUT valid this cycle
Clr_Err  input  1  synchronous one-cycle pulse; clears Overflow and Multi_Err
Res_Ready  input  1  downstream accepts head entry
Res_Valid  output  1  FIFO non-empty
Res_Data  output  2*Width  head entry data
Res_Unit  output  2  head entry source tag: 00 arith, 01 logic, 10 CMP, 11 shift
Count  output  Addr_Width+1  current occupancy, 0..Depth
Busy  output  1  Count >= Depth-1
Overflow  output  1  sticky: a result was dropped
Multi_Err  output  1  sticky: two or more flags were high in one cycle

Behaviour:
- Reset (RST=0, asynchronous): read/write pointers, Count, Overflow and Multi_Err all go to 0. Res_Valid=0, Res_Data=0, Res_Unit=0, Busy=0. FIFO storage is not cleared. A reset mid-stream discards every pending entry.
- Push request: any flag is high at a rising CLK edge.
- Capture: selected unit by priority Arith > Logic > CMP > Shift.
  - Data: Arith_OUT as-is; the other units zero-extended to 2*Width.
  - Tag: written with the data.
- Multi-flag: if two or more flags are high, only the highest-priority unit is captured and Multi_Err is set the same edge.
- Pop: Res_Valid && Res_Ready at the rising edge.
- Head output:
  - Show-ahead: Res_Data/Res_Unit are driven combinationally from the head entry.
  - They are forced to 0 when the FIFO is empty.
  - They stay stable while Res_Valid=1 and Res_Ready=0.
- Latency: a flag at edge N gives Res_Valid=1 after edge N. There is no same-cycle bypass from input flags to output.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push when full:
  - With pop the same edge: push is accepted, Count stays at Depth.
  - Without pop: the entry is dropped, Overflow is set, and storage, pointers and Count are unchanged.
- Pop when empty: impossible, since Res_Valid=0. Res_Ready alone has no effect.
- Push and pop when empty: not possible. Pop needs Res_Valid=1, so the push simply lands.
- Pointer wrap: pointers are Addr_Width bits and wrap modulo Depth. Full/empty are decided by Count, not by pointer compare.
- Busy: combinational from Count. It asserts one entry before full because the ALU has one-cycle latency: an operation already issued when Busy rises still fits.
- Sticky bits:
  - Overflow and Multi_Err hold until Clr_Err or reset.
  - If Clr_Err and a new error event happen on the same edge, the error wins and the bit stays 1.
- All state is updated on the rising CLK edge only, except reset.

Test Plan:
1. Reset then single result: RST 0->1; Logic_Flag=1 with Logic_OUT=16'hA5A5 for one cycle, Res_Ready=0 -> next cycle Res_Valid=1, Res_Data=32'h0000A5A5, Res_Unit=01, Count=1. Pulse Res_Ready -> Res_Valid=0, Res_Data=0, Count=0.
2. Fill, backpressure, wrap:
   - Push four arith results 32'h1, 32'h2, 32'h3, 32'h4 with Res_Ready=0 -> Busy=1 after the third push, Count=4 after the fourth.
   - Fifth push (CMP 16'h0001) -> dropped, Overflow=1.
   - Drain with Res_Ready=1 -> output order 1, 2, 3, 4, all Res_Unit=00.
   - Push 5 more -> correct order across the pointer wrap.
3. Full with simultaneous push/pop: FIFO full; Shift_Flag with 16'h8000 plus Res_Ready=1 on the same edge -> Overflow stays 0, Count stays 4, tail entry is 32'h00008000 tagged 11.
4. Multi-flag: Arith_Flag and Shift_Flag high together, Arith_OUT=32'hFFFF0001 -> one entry 32'hFFFF0001 tagged 00, Multi_Err=1. Clr_Err pulse -> Multi_Err=0. Clr_Err coincident with a new multi-flag event -> Multi_Err stays 1.
5. Stability under stall: head valid, Res_Ready=0 for 5 cycles while new pushes arrive -> Res_Data/Res_Unit unchanged, Count increments per push.
6. Reset mid-stream: Count=3, assert RST=0 asynchronously between edges -> Res_Valid, Count, Busy, Overflow, Multi_Err go to 0 immediately. After release, first new push is the head.
